phy_init_seq: RTL and testbench

Power-on configuration sequencer for the two RGMII PHYs on the board. Holds both PHYs in hardware reset for a fixed time, waits for them to settle, then issues a fixed table of MDIO register writes through the shared MDIO master. The writes set RGMII timing and soft-reset each PHY. Optionally it then services PHY interrupts to track link state. Sits in the core beside the MAC instances and drives `phy0_reset_n`/`phy1_reset_n` and the MDIO master command port.

---
 rtl/phy_init_pkg.sv | 44 ++++
 rtl/phy_init_seq_cnt.sv | 29 ++
 rtl/phy_init_seq.sv | 217 +++++++++++++++++++++
 tb/tb_phy_init_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_init_pkg.sv
// Shared types and constants for the PHY power-on sequencer.
// PHY_INIT_INT_EN adds the interrupt-servicing states to the state enum.
package phy_init_pkg;

  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    RST_SETTLE = 3'd1,
    CMD        = 3'd2,
    DONE       = 3'd3
`ifdef PHY_INIT_INT_EN
    ,
    INT_READ   = 3'd4,
    INT_WAIT   = 3'd5
`endif
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [4:0] REG_BMCR        = 5'd0;
  localparam logic [4:0] REG_PHY_STATUS  = 5'd17;
  localparam logic [4:0] REG_INT_STATUS  = 5'd19;
  localparam logic [4:0] REG_RGMII_DELAY = 5'd20;
  localparam logic [4:0] REG_PAGE        = 5'd22;
  localparam logic [4:0] REG_MODE        = 5'd27;

  typedef struct packed {
    logic [4:0]  reg_addr;
    logic [15:0] data;
  } init_entry_t;

  // Per-PHY write list; the soft reset (BMCR) must stay last so it latches the RGMII settings.
  function automatic init_entry_t init_table(input logic [1:0] idx);
    init_entry_t e;
    case (idx)
      2'd0:    e = '{reg_addr: REG_PAGE,        data: 16'h0000};
      2'd1:    e = '{reg_addr: REG_RGMII_DELAY, data: 16'h0CE2};
      2'd2:    e = '{reg_addr: REG_MODE,        data: 16'h848B};
      default: e = '{reg_addr: REG_BMCR,        data: 16'h9140};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/phy_init_seq_cnt.sv
// Loadable down-counter with terminal-count flag (module phy_init_cnt),
// shared by the reset-hold and settle phases of the sequencer.
module phy_init_cnt #(
  parameter int unsigned     WIDTH       = 21,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so the flag stays asserted until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/phy_init_seq.sv
// Power-on sequencer for the two RGMII PHYs: hardware reset, settle, fixed MDIO
// write table. Define PHY_INIT_INT_EN to also service PHY interrupts for link state.
module phy_init_seq
  import phy_init_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 1250000,
  parameter int unsigned SETTLE_CYCLES = 625000,
  parameter logic [4:0]  PHY0_ADDR     = 5'd16,
  parameter logic [4:0]  PHY1_ADDR     = 5'd17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  output logic        phy0_reset_n,
  output logic        phy1_reset_n,
  input  logic [1:0]  phy_int_n,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0]  cmd_opcode,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  link_up
);

  localparam int unsigned MAX_CYCLES = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic [2:0]       cmd_idx;
  init_entry_t      entry;

  // Counter resets already holding the reset-hold length, so RST_ASSERT lasts exactly RESET_CYCLES.
  phy_init_cnt #(
    .WIDTH       (CNT_W),
    .RESET_VALUE (RESET_LOAD)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  assign entry = init_table(cmd_idx[1:0]);

`ifdef PHY_INIT_INT_EN
  logic [1:0] int_meta;
  logic [1:0] int_sync;
  logic       svc_phy;
  logic       rd_second;
  logic [1:0] link_q;
  logic       unused_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta <= 2'b11;
      int_sync <= 2'b11;
    end else begin
      int_meta <= phy_int_n;
      int_sync <= int_meta;
    end
  end

  assign unused_data = ^{data_out[15:11], data_out[9:0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{phy_int_n, data_out, data_out_valid};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_ASSERT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_value  = SETTLE_LOAD;
    case (state)
      RST_ASSERT: begin
        if (cnt_zero) begin
          state_next = RST_SETTLE;
          cnt_load   = 1'b1;
          cnt_value  = SETTLE_LOAD;
        end
      end
      RST_SETTLE: begin
        if (cnt_zero) begin
          state_next = CMD;
        end
      end
      CMD: begin
        if (cmd_ready && cmd_idx == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (restart) begin
          state_next = RST_ASSERT;
          cnt_load   = 1'b1;
          cnt_value  = RESET_LOAD;
        end
`ifdef PHY_INIT_INT_EN
        else if (!int_sync[0] || !int_sync[1]) begin
          state_next = INT_READ;
        end
`endif
      end
`ifdef PHY_INIT_INT_EN
      INT_READ: begin
        if (cmd_ready) begin
          state_next = INT_WAIT;
        end
      end
      INT_WAIT: begin
        if (data_out_valid) begin
          state_next = rd_second ? DONE : INT_READ;
        end
      end
`endif
      default: state_next = RST_ASSERT;
    endcase
  end

  always_comb begin
    cmd_valid    = 1'b0;
    cmd_phy_addr = '0;
    cmd_reg_addr = '0;
    cmd_data     = '0;
    cmd_opcode   = '0;
    case (state)
      CMD: begin
        cmd_valid    = 1'b1;
        cmd_phy_addr = cmd_idx[2] ? PHY1_ADDR : PHY0_ADDR;
        cmd_reg_addr = entry.reg_addr;
        cmd_data     = entry.data;
        cmd_opcode   = OP_WRITE;
      end
`ifdef PHY_INIT_INT_EN
      INT_READ: begin
        cmd_valid    = 1'b1;
        cmd_phy_addr = svc_phy ? PHY1_ADDR : PHY0_ADDR;
        cmd_reg_addr = rd_second ? REG_PHY_STATUS : REG_INT_STATUS;
        cmd_opcode   = OP_READ;
      end
`endif
      default: ;
    endcase
  end

  // Table index and interrupt bookkeeping; the index parks at 0 outside CMD.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_idx   <= '0;
`ifdef PHY_INIT_INT_EN
      svc_phy   <= 1'b0;
      rd_second <= 1'b0;
      link_q    <= 2'b00;
`endif
    end else begin
      if (state == CMD) begin
        if (cmd_ready) begin
          cmd_idx <= cmd_idx + 3'd1;
        end
      end else begin
        cmd_idx <= '0;
      end
`ifdef PHY_INIT_INT_EN
      if (state == DONE) begin
        rd_second <= 1'b0;
        if (restart) begin
          link_q <= 2'b00;
        end else if (!int_sync[0]) begin
          svc_phy <= 1'b0;
        end else if (!int_sync[1]) begin
          svc_phy <= 1'b1;
        end
      end
      if (state == INT_WAIT && data_out_valid) begin
        rd_second <= 1'b1;
        if (rd_second) begin
          link_q[svc_phy] <= data_out[10];
        end
      end
`endif
    end
  end

  assign phy0_reset_n   = (state != RST_ASSERT);
  assign phy1_reset_n   = (state != RST_ASSERT);
  assign busy           = (state != DONE);
  assign data_out_ready = 1'b1;

`ifdef PHY_INIT_INT_EN
  assign done    = (state == DONE) || (state == INT_READ) || (state == INT_WAIT);
  assign link_up = link_q;
`else
  assign done    = (state == DONE);
  assign link_up = 2'b00;
`endif

endmodule

// File: tb/tb_phy_init_seq.sv
// Scoreboard bench for phy_init_seq with short timer parameters and a small
// PHY/MDIO responder model; the interrupt tests build when PHY_INIT_INT_EN is defined.
module tb_phy_init_seq;

  localparam int RC = 8;
  localparam int SC = 4;

  typedef struct {
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] data;
    logic [1:0]  op;
  } exp_cmd_t;

  logic        clk;
  logic        rst;
  logic        restart;
  logic        phy0_reset_n;
  logic        phy1_reset_n;
  logic [1:0]  phy_int_n;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_opcode;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        busy;
  logic        done;
  logic [1:0]  link_up;

  exp_cmd_t    exp_q[$];
  int          tests;
  int          fails;
  int          ready_mode;
  int          int_gen [2];
  int          int_clr [2];
  int          stray_gen;
  logic [15:0] phy_r17 [2];
  logic [1:0]  exp_link;

  logic [4:0]  tbl_reg  [4] = '{5'd22, 5'd20, 5'd27, 5'd0};
  logic [15:0] tbl_data [4] = '{16'h0000, 16'h0CE2, 16'h848B, 16'h9140};
  logic [4:0]  tbl_phy  [2] = '{5'd16, 5'd17};

  phy_init_seq #(
    .RESET_CYCLES  (RC),
    .SETTLE_CYCLES (SC),
    .PHY0_ADDR     (5'd16),
    .PHY1_ADDR     (5'd17)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .restart        (restart),
    .phy0_reset_n   (phy0_reset_n),
    .phy1_reset_n   (phy1_reset_n),
    .phy_int_n      (phy_int_n),
    .cmd_phy_addr   (cmd_phy_addr),
    .cmd_reg_addr   (cmd_reg_addr),
    .cmd_data       (cmd_data),
    .cmd_opcode     (cmd_opcode),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .busy           (busy),
    .done           (done),
    .link_up        (link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An interrupt line is low while the PHY has raised more events than have been read back.
  assign phy_int_n = {int_gen[1] == int_clr[1], int_gen[0] == int_clr[0]};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      rst     = 1'b0;
      restart = 1'b0;
      case (ready_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = ($urandom_range(0, 9) < 3);
        default: cmd_ready = 1'b0;
      endcase
    end
  endtask

  function automatic void push_init_sequence();
    exp_cmd_t e;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        e.phy  = tbl_phy[p];
        e.rg   = tbl_reg[k];
        e.data = tbl_data[k];
        e.op   = 2'b01;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void push_int_reads(input int p);
    exp_cmd_t e;
    e.phy  = tbl_phy[p];
    e.data = 16'h0000;
    e.op   = 2'b10;
    e.rg   = 5'd19;
    exp_q.push_back(e);
    e.rg   = 5'd17;
    exp_q.push_back(e);
  endfunction

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (!(done && !busy && exp_q.size() == 0) && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkOutput({name, "_finished"}, 32'(n < budget), 32'd1);
  endtask

  task automatic waitQueue(input string name, input int max_size, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > max_size && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkOutput({name, "_reached"}, 32'(n < budget), 32'd1);
  endtask

  // Monitor / PHY model: checks timing and every handshake, answers read commands.
  initial begin : monitor
    exp_cmd_t    e;
    logic [27:0] held;
    logic        held_valid;
    int          low0;
    int          low1;
    int          settle;
    logic        await_first;
    logic        expect_done;
    logic        rsp_pend;
    logic        dv_on;
    logic [15:0] rsp_data;
    int          stray_seen;
    int          pidx;
    held_valid     = 1'b0;
    held           = '0;
    low0           = 0;
    low1           = 0;
    settle         = 0;
    await_first    = 1'b0;
    expect_done    = 1'b0;
    rsp_pend       = 1'b0;
    dv_on          = 1'b0;
    rsp_data       = '0;
    stray_seen     = 0;
    int_clr[0]     = 0;
    int_clr[1]     = 0;
    data_out       = '0;
    data_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (expect_done) begin
        checkOutput("done_after_last_write", 32'({done, busy}), 32'h2);
        expect_done = 1'b0;
      end
      if (!phy0_reset_n) begin
        low0++;
      end else if (low0 != 0) begin
        checkOutput("phy0_reset_low_cycles", 32'(low0), 32'(RC));
        low0        = 0;
        await_first = 1'b1;
        settle      = 0;
      end
      if (!phy1_reset_n) begin
        low1++;
      end else if (low1 != 0) begin
        checkOutput("phy1_reset_low_cycles", 32'(low1), 32'(RC));
        low1 = 0;
      end
      if (await_first) begin
        if (cmd_valid) begin
          checkOutput("settle_cycles", 32'(settle), 32'(SC));
          await_first = 1'b0;
        end else if (phy0_reset_n) begin
          settle++;
        end
      end
      if (held_valid && cmd_valid) begin
        checkOutput("cmd_stable_in_stall", 32'({cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode}), 32'(held));
      end
      held_valid = cmd_valid && !cmd_ready;
      held       = {cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode};
      if (dv_on) begin
        data_out_valid = 1'b0;
        dv_on          = 1'b0;
      end
      if (rsp_pend) begin
        data_out_valid = 1'b1;
        data_out       = rsp_data;
        dv_on          = 1'b1;
        rsp_pend       = 1'b0;
      end else if (stray_gen != stray_seen && !dv_on) begin
        data_out_valid = 1'b1;
        data_out       = 16'hFFFF;
        dv_on          = 1'b1;
        stray_seen     = stray_gen;
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_cmd", 32'({cmd_phy_addr, cmd_reg_addr, cmd_opcode}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("cmd_phy_reg_op", 32'({cmd_phy_addr, cmd_reg_addr, cmd_opcode}), 32'({e.phy, e.rg, e.op}));
          if (e.op == 2'b01) begin
            checkOutput("cmd_write_data", 32'(cmd_data), 32'(e.data));
            if (e.phy == 5'd17 && e.rg == 5'd0) begin
              expect_done = 1'b1;
            end
          end else begin
            checkOutput("busy_done_while_servicing", 32'({busy, done}), 32'h3);
            pidx = (e.phy == 5'd17) ? 1 : 0;
            if (e.rg == 5'd19) begin
              rsp_data      = 16'h0400;
              int_clr[pidx] = int_gen[pidx];
            end else begin
              rsp_data = phy_r17[pidx];
            end
            rsp_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    rst        = 1'b1;
    restart    = 1'b0;
    cmd_ready  = 1'b1;
    ready_mode = 0;
    tests      = 0;
    fails      = 0;
    int_gen[0] = 0;
    int_gen[1] = 0;
    stray_gen  = 0;
    phy_r17[0] = 16'h0000;
    phy_r17[1] = 16'h0000;
    exp_link   = 2'b00;
    push_init_sequence();
    applyStimulus(1);

    checkOutput("reset_phy0_reset_n", 32'(phy0_reset_n), 32'd0);
    checkOutput("reset_phy1_reset_n", 32'(phy1_reset_n), 32'd0);
    checkOutput("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("reset_cmd_fields", 32'({cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode}), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_link_up", 32'(link_up), 32'd0);
    checkOutput("reset_data_out_ready", 32'(data_out_ready), 32'd1);

    // With ready held high the eight writes run back to back.
    n = 0;
    while (!cmd_valid && n < 100) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("first_cmd_seen", 32'(n < 100), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("cmd_phase_cycles", 32'(n), 32'd8);
    checkOutput("all_writes_issued", 32'(exp_q.size()), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

`ifdef PHY_INIT_INT_EN
    phy_r17[0] = 16'h0400;
    push_int_reads(0);
    exp_link   = 2'b01;
    int_gen[0] = int_gen[0] + 1;
    applyStimulus(1);
    waitDone("int_phy0", 200);
    checkOutput("int_phy0_link_up", 32'(link_up), 32'(exp_link));

    for (int r = 0; r < 3; r++) begin
      phy_r17[0] = 16'($urandom);
      phy_r17[1] = 16'($urandom);
      push_int_reads(0);
      push_int_reads(1);
      exp_link   = {phy_r17[1][10], phy_r17[0][10]};
      int_gen[0] = int_gen[0] + 1;
      int_gen[1] = int_gen[1] + 1;
      applyStimulus(1);
      waitDone("int_both", 300);
      checkOutput("int_both_link_up", 32'(link_up), 32'(exp_link));
    end
`else
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) int_gen[0] = int_gen[0] + 1;
      if ($urandom_range(0, 1) == 1) int_gen[1] = int_gen[1] + 1;
      applyStimulus(1);
      if (cmd_valid) n++;
    end
    checkOutput("no_int_cmd_valid_cycles", 32'(n), 32'd0);
    checkOutput("no_int_link_up", 32'(link_up), 32'd0);
    checkOutput("no_int_still_done", 32'(done), 32'd1);
`endif

    // Honoured restart from DONE, then an ignored one mid-sequence under backpressure.
    push_init_sequence();
    exp_link = 2'b00;
    restart  = 1'b1;
    applyStimulus(1);
    checkOutput("restart_clears_done", 32'(done), 32'd0);
    checkOutput("restart_reasserts_reset", 32'({phy1_reset_n, phy0_reset_n}), 32'd0);
    checkOutput("restart_clears_link", 32'(link_up), 32'(exp_link));
    ready_mode = 1;
    waitQueue("restart_mid_cmd", 4, 500);
    restart = 1'b1;
    applyStimulus(1);
    checkOutput("restart_ignored_done", 32'(done), 32'd0);
    checkOutput("restart_ignored_reset_n", 32'(phy0_reset_n), 32'd1);
    checkOutput("restart_ignored_cmd_valid", 32'(cmd_valid), 32'd1);
    waitDone("backpressure_seq", 1000);

    // rst while entry 3 is stalled must drop cmd_valid and rerun everything.
    push_init_sequence();
    restart = 1'b1;
    applyStimulus(1);
    waitQueue("stall_entry3", 5, 500);
    cmd_ready  = 1'b0;
    ready_mode = 2;
    applyStimulus(2);
    checkOutput("stall_entry3_valid", 32'(cmd_valid), 32'd1);
    checkOutput("stall_entry3_fields", 32'({cmd_phy_addr, cmd_reg_addr}), 32'({5'd16, 5'd0}));
    rst = 1'b1;
    exp_q.delete();
    push_init_sequence();
    applyStimulus(1);
    checkOutput("rst_drops_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_reasserts_reset", 32'(phy0_reset_n), 32'd0);
    ready_mode = 1;
    waitDone("rerun_after_rst", 1000);

    // Read data arriving while idle is discarded.
    ready_mode = 0;
    stray_gen  = stray_gen + 1;
    applyStimulus(6);
    checkOutput("stray_data_link_up", 32'(link_up), 32'd0);
    checkOutput("stray_data_done", 32'({done, busy}), 32'h2);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
